regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between the in-order pipeline writeback and one long-latency result source (divider/load unit).
- Buffers long-latency results in a small FIFO and guarantees they are not starved.
- Keeps a pending-write scoreboard so decode can detect RAW hazards on registers awaiting a long-latency result.
- Sits between the writeback stage and the register file; its write outputs drive the regfile write port directly.

---
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback and one long-latency result source. Long-latency results wait
//   in a small FIFO. A starvation counter raises stall_req so the FIFO always
//   drains eventually. A pending-write scoreboard lets decode see RAW hazards
//   on registers that are still waiting for a long-latency result.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   pipe_write/addr/data         pipeline writeback request (no backpressure)
//   ll_valid/ready/addr/data     long-latency result handshake (ll_ready registered)
//   issue_valid/addr             long-latency op issued: mark destination pending
//   query_addr1/2, hazard        decode source registers, combinational busy lookup
//   stall_req                    registered: pipeline must not write this cycle
//   write_dest/address_dest/
//   data_dest                    registered regfile write port
module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_write,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_addr,
  input  logic [31:0] ll_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  query_addr1,
  input  logic [4:0]  query_addr2,
  output logic        hazard,
  output logic        stall_req,
  output logic        write_dest,
  output logic [4:0]  address_dest,
  output logic [31:0] data_dest
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_next;
  logic [SW-1:0] starve_cnt, starve_next;
  logic          src_fifo;
  logic [31:0]   busy, busy_next;
  logic          pipe_grant, fifo_grant, push, fifo_empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    fifo_empty = (count == '0);
    pipe_grant = pipe_write && (pipe_addr != 5'd0);
    fifo_grant = !pipe_grant && !fifo_empty;
    // Register 0 results complete the handshake but are never stored.
    push       = ll_valid && ll_ready && (ll_addr != 5'd0);

    count_next = count;
    if (push && !fifo_grant)
      count_next = count + CW'(1);
    else if (!push && fifo_grant)
      count_next = count - CW'(1);

    starve_next = '0;
    if (!fifo_empty && !fifo_grant)
      starve_next = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SW'(1);
  end

  // A FIFO-sourced write clears its pending bit the cycle it is on the port;
  // a new issue to the same register in that cycle must survive, so set is last.
  always_comb begin
    busy_next = busy;
    if (write_dest && src_fifo)
      busy_next[address_dest] = 1'b0;
    if (issue_valid && (issue_addr != 5'd0))
      busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign hazard = busy[query_addr1] | busy[query_addr2];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ll_addr;
      fifo_data[wr_ptr] <= ll_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      ll_ready     <= 1'b0;
      starve_cnt   <= '0;
      stall_req    <= 1'b0;
      write_dest   <= 1'b0;
      address_dest <= 5'd0;
      data_dest    <= 32'd0;
      src_fifo     <= 1'b0;
      busy         <= 32'd0;
    end else begin
      if (push)
        wr_ptr <= next_ptr(wr_ptr);
      if (fifo_grant)
        rd_ptr <= next_ptr(rd_ptr);
      count      <= count_next;
      ll_ready   <= (count_next < CW'(DEPTH));
      starve_cnt <= starve_next;
      stall_req  <= (starve_next == SW'(STARVE_LIMIT));
      write_dest <= pipe_grant || fifo_grant;
      src_fifo   <= fifo_grant;
      if (pipe_grant) begin
        address_dest <= pipe_addr;
        data_dest    <= pipe_data;
      end else if (fifo_grant) begin
        address_dest <= fifo_addr[rd_ptr];
        data_dest    <= fifo_data[rd_ptr];
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_write;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  query_addr1;
  logic [4:0]  query_addr2;
  logic        hazard;
  logic        stall_req;
  logic        write_dest;
  logic [4:0]  address_dest;
  logic [31:0] data_dest;

  int total = 0;
  int bad = 0;

  // Reference model state: queue of pending results, pending set, and the
  // expected registered outputs.
  logic [36:0] m_q[$];
  logic [31:0] m_busy;
  int          m_starve;
  logic        m_stall, m_ready, m_wr, m_src_fifo;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .pipe_write(pipe_write), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_addr(ll_addr), .ll_data(ll_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .query_addr1(query_addr1), .query_addr2(query_addr2), .hazard(hazard),
    .stall_req(stall_req), .write_dest(write_dest),
    .address_dest(address_dest), .data_dest(data_dest)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance past the edge, update the model.
  task automatic cycle(input logic rn, input logic pw, input logic [4:0] pa,
                       input logic [31:0] pd, input logic lv, input logic [4:0] la,
                       input logic [31:0] ld, input logic iv, input logic [4:0] ia);
    int  pre;
    logic gp, gf, acc;
    logic [36:0] e;
    reset_n = rn; pipe_write = pw; pipe_addr = pa; pipe_data = pd;
    ll_valid = lv; ll_addr = la; ll_data = ld; issue_valid = iv; issue_addr = ia;
    @(posedge clk);
    if (!rn) begin
      m_q.delete();
      m_busy = '0; m_starve = 0; m_stall = 0; m_ready = 0;
      m_wr = 0; m_src_fifo = 0; m_addr = '0; m_data = '0;
    end else begin
      pre = m_q.size();
      gp  = pw && (pa != 0);
      gf  = !gp && (pre > 0);
      acc = lv && m_ready;
      if (m_wr && m_src_fifo) m_busy[m_addr] = 1'b0;
      if (iv && ia != 0) m_busy[ia] = 1'b1;
      if (gp) begin
        m_wr = 1; m_src_fifo = 0; m_addr = pa; m_data = pd;
      end else if (gf) begin
        e = m_q.pop_front();
        m_wr = 1; m_src_fifo = 1; m_addr = e[36:32]; m_data = e[31:0];
      end else begin
        m_wr = 0; m_src_fifo = 0;
      end
      if (acc && la != 0) m_q.push_back({la, ld});
      if (pre > 0 && !gf) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
      else m_starve = 0;
      m_stall = (m_starve == STARVE_LIMIT);
      m_ready = (m_q.size() < DEPTH);
    end
    #1;
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    query_addr1 = 0; query_addr2 = 0;
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 3, 32'h1111, 1, 4, 32'h2222, 1, 6);
      total++;
      if (write_dest !== 1'b0) begin bad++; $display("FAIL reset_wr: got %b want 0", write_dest); end
      total++;
      if (ll_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ll_ready); end
    end
    idle();
    total++;
    if (ll_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset: got %b want 1", ll_ready); end
    total++;
    if (stall_req !== 1'b0 || hazard !== 1'b0 || write_dest !== 1'b0) begin
      bad++; $display("FAIL post_reset_outs: got stall=%b hz=%b wr=%b want 0 0 0", stall_req, hazard, write_dest);
    end
  endtask

  task automatic test_pipe_write();
    cycle(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    total++;
    if (write_dest !== 1'b1 || address_dest !== 5'd5 || data_dest !== 32'hDEADBEEF) begin
      bad++; $display("FAIL pipe_write: got %b %0d %h want 1 5 deadbeef", write_dest, address_dest, data_dest);
    end
    idle();
    total++;
    if (write_dest !== 1'b0) begin bad++; $display("FAIL pipe_pulse_end: got %b want 0", write_dest); end
  endtask

  task automatic test_hazard();
    query_addr1 = 7; query_addr2 = 0;
    #1;
    total++;
    if (hazard !== 1'b0) begin bad++; $display("FAIL hazard_pre: got %b want 0", hazard); end
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 7);
    total++;
    if (hazard !== 1'b1) begin bad++; $display("FAIL hazard_set: got %b want 1", hazard); end
    cycle(1, 0, 0, 0, 1, 7, 32'h1234, 0, 0);
    total++;
    if (write_dest !== 1'b0 || hazard !== 1'b1) begin
      bad++; $display("FAIL hazard_push: got wr=%b hz=%b want 0 1", write_dest, hazard);
    end
    idle();
    total++;
    if (write_dest !== 1'b1 || address_dest !== 5'd7 || data_dest !== 32'h1234 || hazard !== 1'b1) begin
      bad++; $display("FAIL ll_write: got %b %0d %h hz=%b want 1 7 1234 1", write_dest, address_dest, data_dest, hazard);
    end
    idle();
    total++;
    if (hazard !== 1'b0 || write_dest !== 1'b0) begin
      bad++; $display("FAIL hazard_clear: got hz=%b wr=%b want 0 0", hazard, write_dest);
    end
    query_addr1 = 0;
  endtask

  task automatic test_starvation();
    int n;
    cycle(1, 1, 1, 32'hA0, 1, 9, 32'h9999, 0, 0);
    n = 1;
    while (stall_req !== 1'b1 && n < 10) begin
      cycle(1, 1, 1, 32'hA0 + n, 0, 0, 0, 0, 0);
      n++;
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL starve_cycles: got %0d want 5", n); end
    idle();
    total++;
    if (write_dest !== 1'b1 || address_dest !== 5'd9 || data_dest !== 32'h9999) begin
      bad++; $display("FAIL starve_drain: got %b %0d %h want 1 9 9999", write_dest, address_dest, data_dest);
    end
    total++;
    if (stall_req !== 1'b0) begin bad++; $display("FAIL starve_release: got %b want 0", stall_req); end
    idle();
  endtask

  task automatic test_full();
    cycle(1, 1, 2, 32'h22, 1, 10, 32'hA, 0, 0);
    cycle(1, 1, 2, 32'h23, 1, 11, 32'hB, 0, 0);
    total++;
    if (ll_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", ll_ready); end
    cycle(1, 1, 2, 32'h24, 1, 12, 32'hC, 0, 0);
    total++;
    if (ll_ready !== 1'b0 || address_dest !== 5'd2) begin
      bad++; $display("FAIL full_hold: got rdy=%b addr=%0d want 0 2", ll_ready, address_dest);
    end
    cycle(1, 0, 0, 0, 1, 12, 32'hC, 0, 0);
    total++;
    if (write_dest !== 1'b1 || address_dest !== 5'd10 || data_dest !== 32'hA || ll_ready !== 1'b1) begin
      bad++; $display("FAIL drain_first: got %b %0d %h rdy=%b want 1 10 a 1", write_dest, address_dest, data_dest, ll_ready);
    end
    cycle(1, 0, 0, 0, 1, 12, 32'hC, 0, 0);
    total++;
    if (write_dest !== 1'b1 || address_dest !== 5'd11 || data_dest !== 32'hB) begin
      bad++; $display("FAIL drain_second: got %b %0d %h want 1 11 b", write_dest, address_dest, data_dest);
    end
    idle();
    total++;
    if (write_dest !== 1'b1 || address_dest !== 5'd12 || data_dest !== 32'hC) begin
      bad++; $display("FAIL drain_held: got %b %0d %h want 1 12 c", write_dest, address_dest, data_dest);
    end
    idle();
  endtask

  task automatic test_x0();
    query_addr1 = 0; query_addr2 = 0;
    cycle(1, 1, 0, 32'h55, 0, 0, 0, 1, 0);
    total++;
    if (write_dest !== 1'b0 || hazard !== 1'b0) begin
      bad++; $display("FAIL x0_pipe: got wr=%b hz=%b want 0 0", write_dest, hazard);
    end
    total++;
    if (ll_ready !== 1'b1) begin bad++; $display("FAIL x0_ready_pre: got %b want 1", ll_ready); end
    cycle(1, 0, 0, 0, 1, 0, 32'h66, 0, 0);
    total++;
    if (write_dest !== 1'b0 || ll_ready !== 1'b1) begin
      bad++; $display("FAIL x0_ll: got wr=%b rdy=%b want 0 1", write_dest, ll_ready);
    end
    idle();
    total++;
    if (write_dest !== 1'b0) begin bad++; $display("FAIL x0_ll_discard: got %b want 0", write_dest); end
  endtask

  task automatic test_random();
    logic rn, pw, lv, iv;
    logic [4:0] pa, la, ia;
    logic [31:0] pd, ld;
    for (int i = 0; i < 600; i++) begin
      rn = ($urandom_range(0, 149) != 0);
      pw = m_stall ? 1'b0 : ($urandom_range(0, 2) != 0);
      pa = 5'($urandom_range(0, 7));
      pd = $urandom;
      lv = 1'($urandom_range(0, 1));
      la = 5'($urandom_range(0, 7));
      ld = $urandom;
      iv = ($urandom_range(0, 2) == 0);
      ia = 5'($urandom_range(0, 7));
      query_addr1 = 5'($urandom_range(0, 7));
      query_addr2 = 5'($urandom_range(0, 7));
      cycle(rn, pw, pa, pd, lv, la, ld, iv, ia);
      total++;
      if (write_dest !== m_wr) begin
        bad++; $display("FAIL rnd_wr @%0d: got %b want %b", i, write_dest, m_wr);
      end
      if (m_wr) begin
        total++;
        if (address_dest !== m_addr || data_dest !== m_data) begin
          bad++; $display("FAIL rnd_port @%0d: got %0d %h want %0d %h", i, address_dest, data_dest, m_addr, m_data);
        end
      end
      total++;
      if (ll_ready !== m_ready) begin
        bad++; $display("FAIL rnd_ready @%0d: got %b want %b", i, ll_ready, m_ready);
      end
      total++;
      if (stall_req !== m_stall) begin
        bad++; $display("FAIL rnd_stall @%0d: got %b want %b", i, stall_req, m_stall);
      end
      total++;
      if (hazard !== (m_busy[query_addr1] | m_busy[query_addr2])) begin
        bad++; $display("FAIL rnd_hazard @%0d: got %b want %b", i, hazard, m_busy[query_addr1] | m_busy[query_addr2]);
      end
    end
  endtask

  initial begin
    reset_n = 0; pipe_write = 0; pipe_addr = 0; pipe_data = 0;
    ll_valid = 0; ll_addr = 0; ll_data = 0; issue_valid = 0; issue_addr = 0;
    query_addr1 = 0; query_addr2 = 0;
    m_busy = '0; m_starve = 0; m_stall = 0; m_ready = 0;
    m_wr = 0; m_src_fifo = 0; m_addr = '0; m_data = '0;
    test_reset();
    test_pipe_write();
    test_hazard();
    test_starvation();
    test_full();
    test_x0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
